// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture/generator pair: state encoding and default widths.
package pwm_pkg;

  localparam int unsigned PWM_COUNTER_WIDTH = 16;
  localparam int unsigned PWM_SYNC_STAGES   = 2;

  localparam logic [1:0] ST_ACQ  = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/pwm_sync_edge.sv
// Metastability synchronizer for an asynchronous PWM pin, plus rise/fall detection on the
// synchronized level.
module pwm_sync_edge
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~dly_q;
  assign fall_c = ~level & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a PWM input in clk cycles and reports a stuck
// input after a programmable timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = PWM_COUNTER_WIDTH,
  parameter int unsigned SYNC_STAGES   = PWM_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwm_i,
  input  logic [COUNTER_WIDTH-1:0] timeout_cycles,
  output logic [COUNTER_WIDTH-1:0] high_o,
  output logic [COUNTER_WIDTH-1:0] period_o,
  output logic                     valid_o,
  output logic                     stuck_o,
  output logic                     level_o
);

  localparam int unsigned W = COUNTER_WIDTH;

  logic         s;
  logic         rise;
  logic         fall;
  logic [1:0]   state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] hi_lat, hi_lat_n;
  logic [W-1:0] high_n, period_n;
  logic         valid_n, stuck_n;
  logic [W-1:0] limit;
  logic [W-1:0] cnt_inc;
  logic         timeout;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm   (pwm_i),
    .level (s),
    .rise_c(rise),
    .fall_c(fall)
  );

  // A zero timeout selects the largest count; the increment saturates so cnt can never wrap.
  assign limit   = (timeout_cycles == '0) ? '1 : timeout_cycles;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + W'(1);
  assign timeout = (cnt >= limit) && !rise && !fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ACQ;
      cnt      <= '0;
      hi_lat   <= '0;
      high_o   <= '0;
      period_o <= '0;
      valid_o  <= 1'b0;
      stuck_o  <= 1'b0;
      level_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hi_lat   <= hi_lat_n;
      high_o   <= high_n;
      period_o <= period_n;
      valid_o  <= valid_n;
      stuck_o  <= stuck_n;
      level_o  <= s;
    end
  end

  // Edges take priority over the timeout; the cycle of an edge is itself counted.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt_inc;
    hi_lat_n = hi_lat;
    high_n   = high_o;
    period_n = period_o;
    stuck_n  = stuck_o;
    valid_n  = 1'b0;
    if (timeout) begin
      state_n  = ST_ACQ;
      cnt_n    = '0;
      high_n   = s ? limit : '0;
      period_n = limit;
      stuck_n  = 1'b1;
      valid_n  = 1'b1;
    end else begin
      case (state)
        ST_ACQ: begin
          if (rise) begin
            cnt_n   = W'(1);
            state_n = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            hi_lat_n = cnt;
            state_n  = ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_n   = hi_lat;
            period_n = cnt;
            stuck_n  = 1'b0;
            valid_n  = 1'b1;
            cnt_n    = W'(1);
            state_n  = ST_HIGH;
          end
        end
        default: begin
          state_n = ST_ACQ;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule
